bm_stmt_seq_param: RTL and testbench

//   Parametrised statement-coverage microbenchmark; successor to the fixed 4-bit case/if-else benchmark.

---
 rtl/bm_stmt_seq_param_pkg.sv | 14 +
 rtl/bm_stmt_seq_counter.sv | 66 ++++++
 rtl/bm_stmt_seq_param.sv | 63 ++++++
 tb/tb_bm_stmt_seq_param.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bm_stmt_seq_param_pkg.sv
// Shared definitions for the bm_stmt_seq_param microbenchmark: FSM state
// encoding and the constants produced by the priority chain.
package bm_stmt_seq_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int OUT2_ONE  = 1;
  localparam int OUT2_FOUR = 4;

endpackage

// File: rtl/bm_stmt_seq_counter.sv
// Start/done counter FSM: counts down from, or up to, a target latched on start.
// busy and done are decoded straight from the state register.
module bm_stmt_seq_counter
  import bm_stmt_seq_param_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [BITS-1:0] a_in,
  input  logic            start,
  input  logic            mode,
  output logic [BITS-1:0] count,
  output logic            busy,
  output logic            done
);

  localparam logic [BITS-1:0] ONE = BITS'(1);

  state_t          state;
  logic [BITS-1:0] target;
  logic            mode_r;
  logic [BITS-1:0] count_inc;
  logic [BITS-1:0] count_dec;

  assign count_inc = count + ONE;
  assign count_dec = count - ONE;

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      target <= '0;
      mode_r <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            target <= a_in;
            mode_r <= mode;
            count  <= mode ? '0 : a_in;
            state  <= (a_in == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // Terminal checks look one step ahead, so count never wraps.
          if (!mode_r) begin
            count <= count_dec;
            if (count == ONE) state <= ST_DONE;
          end else begin
            count <= count_inc;
            if (count_inc == target) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/bm_stmt_seq_param.sv
// Parametrised statement-coverage microbenchmark: complement table, priority
// chain, b_in history shift register and a start/done counter.
module bm_stmt_seq_param
  import bm_stmt_seq_param_pkg::*;
#(
  parameter int BITS  = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BITS-1:0]  a_in,
  input  logic             b_in,
  input  logic             start,
  input  logic             mode,
  output logic [BITS-1:0]  out0,
  output logic             out1,
  output logic [BITS-1:0]  out2,
  output logic             out3,
  output logic [DEPTH-1:0] hist,
  output logic [BITS-1:0]  count,
  output logic             busy,
  output logic             done
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out0 <= '0;
      out1 <= 1'b0;
      out2 <= '0;
      out3 <= 1'b0;
      hist <= '0;
    end else begin
      out0 <= ~a_in;
      out1 <= ~b_in;
      hist <= {hist[DEPTH-2:0], b_in};
      // b_in has priority over the a_in zero test.
      if (!b_in) begin
        out3 <= 1'b1;
        out2 <= BITS'(OUT2_ONE);
      end else if (a_in == '0) begin
        out3 <= 1'b0;
        out2 <= BITS'(OUT2_FOUR);
      end else begin
        out3 <= 1'b1;
        out2 <= '0;
      end
    end
  end

  bm_stmt_seq_counter #(
    .BITS (BITS)
  ) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .a_in    (a_in),
    .start   (start),
    .mode    (mode),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

endmodule

// File: tb/tb_bm_stmt_seq_param.sv
// Self-checking bench for bm_stmt_seq_param: default 4/4 instance plus an
// 8/8 instance for the parameter sweep.
module tb_bm_stmt_seq_param;

  logic       clock;
  logic       reset_n;
  logic [3:0] a_in;
  logic       b_in, start, mode;
  logic [3:0] out0, out2, hist, count;
  logic       out1, out3, busy, done;

  logic [7:0] a8;
  logic       b8, start8, mode8;
  logic [7:0] out0_8, out2_8, hist8, count8;
  logic       out1_8, out3_8, busy8, done8;

  int n_checks = 0;
  int n_errors = 0;

  bm_stmt_seq_param #(.BITS(4), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
    .start(start), .mode(mode), .out0(out0), .out1(out1), .out2(out2),
    .out3(out3), .hist(hist), .count(count), .busy(busy), .done(done)
  );

  bm_stmt_seq_param #(.BITS(8), .DEPTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .a_in(a8), .b_in(b8),
    .start(start8), .mode(mode8), .out0(out0_8), .out1(out1_8), .out2(out2_8),
    .out3(out3_8), .hist(hist8), .count(count8), .busy(busy8), .done(done8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] a;
    logic       b;
    logic [3:0] e_out0;
    logic       e_out1;
    logic [3:0] e_out2;
    logic       e_out3;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add_vec(input logic [3:0] a, input logic b, input logic [3:0] e0,
                         input logic e1, input logic [3:0] e2, input logic e3);
    vec_t v;
    v.a = a; v.b = b; v.e_out0 = e0; v.e_out1 = e1; v.e_out2 = e2; v.e_out3 = e3;
    vecs.push_back(v);
  endtask

  initial begin
    int n_busy;
    int cyc;
    logic [3:0] pat4 [4];
    logic       pat8 [8];

    // Hand-written vectors first, then the full sweep.
    add_vec(4'b0101, 1'b1, 4'b1010, 1'b0, 4'd0, 1'b1);
    add_vec(4'd0,    1'b0, 4'hF,    1'b1, 4'd1, 1'b1);
    add_vec(4'd0,    1'b1, 4'hF,    1'b0, 4'd4, 1'b0);
    add_vec(4'd7,    1'b1, 4'h8,    1'b0, 4'd0, 1'b1);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 2; b++) begin
        logic [3:0] av;
        av = 4'(a);
        add_vec(av, b[0], ~av, ~b[0],
                (b == 0) ? 4'd1 : ((a == 0) ? 4'd4 : 4'd0),
                (b == 0) ? 1'b1 : ((a == 0) ? 1'b0 : 1'b1));
      end
    end

    reset_n = 1'b0; a_in = '0; b_in = 0; start = 0; mode = 0;
    a8 = '0; b8 = 0; start8 = 0; mode8 = 0;
    repeat (2) step();
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset_n = 1'b1;
    step();

    // Reset mid-RUN aborts immediately.
    a_in = 4'd9; mode = 0; start = 1; b_in = 1;
    step();
    start = 0;
    step(); step();
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_count", 32'(count), 7);
    reset_n = 1'b0;
    #1;
    check("midrun_rst_out0", 32'(out0), 0);
    check("midrun_rst_out1", 32'(out1), 0);
    check("midrun_rst_out2", 32'(out2), 0);
    check("midrun_rst_out3", 32'(out3), 0);
    check("midrun_rst_hist", 32'(hist), 0);
    check("midrun_rst_count", 32'(count), 0);
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_done", 32'(done), 0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_done", 32'(done), 0);
      check("post_rst_count", 32'(count), 0);
    end

    // Table-driven complement and priority checks.
    foreach (vecs[i]) begin
      a_in = vecs[i].a; b_in = vecs[i].b;
      step();
      check($sformatf("tbl%0d_out0", i), 32'(out0), 32'(vecs[i].e_out0));
      check($sformatf("tbl%0d_out1", i), 32'(out1), 32'(vecs[i].e_out1));
      check($sformatf("tbl%0d_out2", i), 32'(out2), 32'(vecs[i].e_out2));
      check($sformatf("tbl%0d_out3", i), 32'(out3), 32'(vecs[i].e_out3));
    end

    // Down count from 3; a_in/mode changes after launch must not matter.
    a_in = 4'd3; mode = 0; start = 1;
    step();
    start = 0; a_in = 4'd9; mode = 1;
    check("dn_c0_count", 32'(count), 3);
    check("dn_c0_busy", 32'(busy), 1);
    step();
    check("dn_c1_count", 32'(count), 2);
    check("dn_c1_busy", 32'(busy), 1);
    step();
    check("dn_c2_count", 32'(count), 1);
    check("dn_c2_busy", 32'(busy), 1);
    step();
    check("dn_end_count", 32'(count), 0);
    check("dn_end_busy", 32'(busy), 0);
    check("dn_end_done", 32'(done), 1);
    step();
    check("dn_idle_done", 32'(done), 0);
    check("dn_idle_count", 32'(count), 0);

    // Up count to 15 with a second start during RUN.
    a_in = 4'd15; mode = 1; start = 1;
    step();
    start = 0;
    n_busy = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) n_busy++;
      if (cyc == 5) begin a_in = 4'd2; mode = 0; start = 1; end
      else start = 0;
      step();
      cyc++;
    end
    start = 0;
    check("up_done_seen", 32'(done), 1);
    check("up_busy_cycles", 32'(n_busy), 15);
    check("up_final_count", 32'(count), 15);
    check("up_done_busy", 32'(busy), 0);
    step();
    check("up_idle_done", 32'(done), 0);
    check("up_idle_busy", 32'(busy), 0);
    check("up_idle_count", 32'(count), 15);

    // Zero target goes straight to DONE.
    a_in = 4'd0; mode = 1; start = 1;
    step();
    start = 0;
    check("zero_busy", 32'(busy), 0);
    check("zero_done", 32'(done), 1);
    check("zero_count", 32'(count), 0);
    step();
    check("zero_idle_done", 32'(done), 0);
    check("zero_idle_busy", 32'(busy), 0);

    // History 1,0,1,1 on the 4-deep instance.
    pat4 = '{4'd1, 4'd0, 4'd1, 4'd1};
    for (int i = 0; i < 4; i++) begin
      b_in = pat4[i][0];
      step();
    end
    check("hist4", 32'(hist), 32'b1011);

    // Parameter sweep on the 8/8 instance.
    pat8 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      b8 = pat8[i];
      step();
    end
    check("hist8", 32'(hist8), 32'hCA);
    a8 = 8'hA5; b8 = 1'b1;
    step();
    check("w8_out0", 32'(out0_8), 32'h5A);
    check("w8_out2_zero", 32'(out2_8), 0);
    a8 = 8'h00; b8 = 1'b1;
    step();
    check("w8_out2_four", 32'(out2_8), 4);
    check("w8_out3", 32'(out3_8), 0);
    a8 = 8'd2; mode8 = 0; start8 = 1;
    step();
    start8 = 0;
    check("w8_dn_count", 32'(count8), 2);
    step(); step();
    check("w8_dn_done", 32'(done8), 1);
    check("w8_dn_final", 32'(count8), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
